free_list_mp: RTL and testbench

- Multi-port circular free list of physical register tags for the OoO rename stage.
- Allocates up to ALLOC_WIDTH tags and accepts up to RET_WIDTH returned tags per cycle.
- Keeps NUM_CKPT head-pointer checkpoints so rename state recovers in one cycle on branch mispredict.
- Sits between the rename unit (allocate, save checkpoint), the commit/ROB (return) and the branch unit (restore).

---
 rtl/free_list_mp.sv | 123 ++++++++++++
 tb/tb_free_list_mp.sv | 274 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/free_list_mp.sv
// Multi-port circular free list of physical register tags for the rename stage.
// Zero-latency all-or-nothing allocation, multi-lane returns, and head-pointer checkpoints.
module free_list_mp #(
    parameter int unsigned NUM_PHYS_REGS = 64,
    parameter int unsigned NUM_ARCH_REGS = 32,
    parameter int unsigned TAG_WIDTH     = 6,
    parameter int unsigned ALLOC_WIDTH   = 2,
    parameter int unsigned RET_WIDTH     = 2,
    parameter int unsigned NUM_CKPT      = 4,
    parameter int unsigned CKPT_ID_W     = 2
) (
    input  logic                             clk,
    input  logic                             rst_n,
    input  logic [ALLOC_WIDTH-1:0]           alloc_req,
    output logic                             alloc_ok,
    output logic [ALLOC_WIDTH*TAG_WIDTH-1:0] alloc_tag,
    input  logic [RET_WIDTH-1:0]             ret_valid,
    input  logic [RET_WIDTH*TAG_WIDTH-1:0]   ret_tag,
    input  logic                             ckpt_save,
    input  logic [CKPT_ID_W-1:0]             ckpt_save_id,
    input  logic                             ckpt_restore,
    input  logic [CKPT_ID_W-1:0]             ckpt_restore_id,
    output logic [TAG_WIDTH:0]               free_count,
    output logic                             empty,
    output logic                             full,
    output logic                             overflow_err
);

    localparam int unsigned PTR_W     = TAG_WIDTH + 1;
    localparam int unsigned INIT_FREE = NUM_PHYS_REGS - NUM_ARCH_REGS;
    localparam logic [PTR_W-1:0] CAP       = PTR_W'(NUM_PHYS_REGS);
    localparam logic [PTR_W-1:0] INIT_TAIL = PTR_W'(INIT_FREE);

    logic [TAG_WIDTH-1:0] entries [NUM_PHYS_REGS];
    logic [PTR_W-1:0]     ckpt    [NUM_CKPT];
    logic [PTR_W-1:0]     head;
    logic [PTR_W-1:0]     tail;
    logic [PTR_W-1:0]     head_next;
    logic [PTR_W-1:0]     tail_next;
    logic [PTR_W-1:0]     n_alloc;
    logic [PTR_W-1:0]     occ;
    logic                 drop;
    logic [RET_WIDTH-1:0] ret_we;
    logic [TAG_WIDTH-1:0] ret_addr [RET_WIDTH];

    assign free_count = tail - head;
    assign empty      = (free_count == '0);
    assign full       = (free_count == CAP);

    // k-th requesting lane reads entry[head+k]; n_alloc ends as the popcount
    always_comb begin
        n_alloc   = '0;
        alloc_tag = '0;
        for (int i = 0; i < int'(ALLOC_WIDTH); i++) begin
            if (alloc_req[i]) begin
                alloc_tag[i*TAG_WIDTH +: TAG_WIDTH] = entries[TAG_WIDTH'(head + n_alloc)];
                n_alloc = n_alloc + PTR_W'(1);
            end
        end
    end

    assign alloc_ok = (free_count >= n_alloc) && !ckpt_restore;

    always_comb begin
        head_next = head;
        if (ckpt_restore) begin
            head_next = ckpt[ckpt_restore_id];
        end else if (alloc_ok) begin
            head_next = head + n_alloc;
        end
    end

    // Returns fill from tail in lane order; capacity is judged against the post-alloc/restore head
    always_comb begin
        tail_next = tail;
        occ       = tail - head_next;
        drop      = 1'b0;
        ret_we    = '0;
        for (int j = 0; j < int'(RET_WIDTH); j++) begin
            ret_addr[j] = '0;
            if (ret_valid[j]) begin
                if (occ < CAP) begin
                    ret_we[j]   = 1'b1;
                    ret_addr[j] = TAG_WIDTH'(tail_next);
                    tail_next   = tail_next + PTR_W'(1);
                    occ         = occ + PTR_W'(1);
                end else begin
                    drop = 1'b1;
                end
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            head         <= '0;
            tail         <= INIT_TAIL;
            overflow_err <= 1'b0;
            for (int unsigned i = 0; i < NUM_PHYS_REGS; i++) begin
                entries[i] <= (i < INIT_FREE) ? TAG_WIDTH'(NUM_ARCH_REGS + i) : '0;
            end
            for (int unsigned c = 0; c < NUM_CKPT; c++) begin
                ckpt[c] <= '0;
            end
        end else begin
            head <= head_next;
            tail <= tail_next;
            if (drop) begin
                overflow_err <= 1'b1;
            end
            for (int j = 0; j < int'(RET_WIDTH); j++) begin
                if (ret_we[j]) begin
                    entries[ret_addr[j]] <= ret_tag[j*TAG_WIDTH +: TAG_WIDTH];
                end
            end
            // head_next already reflects a same-cycle restore
            if (ckpt_save) begin
                ckpt[ckpt_save_id] <= head_next;
            end
        end
    end

endmodule

// File: tb/tb_free_list_mp.sv
// Bench for free_list_mp: queue-style reference model checked every cycle,
// plus directed scenarios with literal expectations.
module tb_free_list_mp;

    localparam int NPR = 64;
    localparam int NAR = 32;
    localparam int TW  = 6;

    logic          clk;
    logic          rst_n;
    logic [1:0]    alloc_req;
    logic          alloc_ok;
    logic [11:0]   alloc_tag;
    logic [1:0]    ret_valid;
    logic [11:0]   ret_tag;
    logic          ckpt_save;
    logic [1:0]    ckpt_save_id;
    logic          ckpt_restore;
    logic [1:0]    ckpt_restore_id;
    logic [6:0]    free_count;
    logic          empty;
    logic          full;
    logic          overflow_err;

    free_list_mp dut (
        .clk             (clk),
        .rst_n           (rst_n),
        .alloc_req       (alloc_req),
        .alloc_ok        (alloc_ok),
        .alloc_tag       (alloc_tag),
        .ret_valid       (ret_valid),
        .ret_tag         (ret_tag),
        .ckpt_save       (ckpt_save),
        .ckpt_save_id    (ckpt_save_id),
        .ckpt_restore    (ckpt_restore),
        .ckpt_restore_id (ckpt_restore_id),
        .free_count      (free_count),
        .empty           (empty),
        .full            (full),
        .overflow_err    (overflow_err)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int n_checks = 0;
    int n_pass   = 0;

    // Reference model: unbounded integer pointers over a circular store of tags
    int m_mem [NPR];
    int m_head;
    int m_tail;
    int m_ck [4];
    bit m_ovf;

    // Ownership tracking for the random phase
    bit own_en = 1'b0;
    bit owned [NPR];
    int held [$];

    task automatic chk(input string name, input int act, input int exp);
        n_checks++;
        if (act == exp) n_pass++;
        else $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
    endtask

    task automatic model_reset();
        for (int i = 0; i < NPR; i++) begin
            m_mem[i] = (i < NPR - NAR) ? NAR + i : 0;
            owned[i] = (i < NAR);
        end
        m_head = 0;
        m_tail = NPR - NAR;
        for (int c = 0; c < 4; c++) m_ck[c] = 0;
        m_ovf = 1'b0;
        held.delete();
        for (int i = 0; i < NAR; i++) held.push_back(i);
    endtask

    // Per-cycle compare against the model, then advance the model with this cycle's inputs
    always @(negedge clk) begin
        int cnt;
        int n;
        int k;
        int t;
        int nh;
        bit ok;
        if (!rst_n) begin
            model_reset();
            chk("rst_free_count", int'(free_count), NPR - NAR);
            chk("rst_empty", int'(empty), 0);
            chk("rst_full", int'(full), 0);
            chk("rst_overflow", int'(overflow_err), 0);
        end else begin
            cnt = m_tail - m_head;
            n   = $countones(alloc_req);
            ok  = (cnt >= n) && !ckpt_restore;
            chk("alloc_ok", int'(alloc_ok), int'(ok));
            chk("free_count", int'(free_count), cnt);
            chk("empty", int'(empty), int'(cnt == 0));
            chk("full", int'(full), int'(cnt == NPR));
            chk("overflow_err", int'(overflow_err), int'(m_ovf));
            if (ok) begin
                k = 0;
                for (int i = 0; i < 2; i++) begin
                    if (alloc_req[i]) begin
                        t = m_mem[(m_head + k) % NPR];
                        chk("alloc_tag", int'(alloc_tag[i*TW +: TW]), t);
                        if (own_en) begin
                            chk("tag_unique", int'(owned[t]), 0);
                            owned[t] = 1'b1;
                            held.push_back(t);
                        end
                        k++;
                    end
                end
            end
            nh = ckpt_restore ? m_ck[ckpt_restore_id] : m_head + (ok ? n : 0);
            for (int j = 0; j < 2; j++) begin
                if (ret_valid[j]) begin
                    t = int'(ret_tag[j*TW +: TW]);
                    if (m_tail - nh < NPR) begin
                        m_mem[m_tail % NPR] = t;
                        m_tail++;
                        if (own_en) owned[t] = 1'b0;
                    end else begin
                        m_ovf = 1'b1;
                    end
                end
            end
            if (ckpt_save) m_ck[ckpt_save_id] = nh;
            m_head = nh;
        end
    end

    task automatic drive(input logic [1:0] rq, input logic [1:0] rv, input int t0, input int t1,
                         input bit sv, input int sid, input bit rs, input int rid);
        @(posedge clk);
        #1;
        alloc_req       = rq;
        ret_valid       = rv;
        ret_tag         = {6'(t1), 6'(t0)};
        ckpt_save       = sv;
        ckpt_save_id    = 2'(sid);
        ckpt_restore    = rs;
        ckpt_restore_id = 2'(rid);
    endtask

    task automatic idle();
        drive(2'b00, 2'b00, 0, 0, 1'b0, 0, 1'b0, 0);
    endtask

    task automatic alloc2();
        drive(2'b11, 2'b00, 0, 0, 1'b0, 0, 1'b0, 0);
    endtask

    task automatic do_reset();
        @(posedge clk);
        #1;
        rst_n = 1'b0;
        alloc_req = '0; ret_valid = '0; ret_tag = '0;
        ckpt_save = 1'b0; ckpt_save_id = '0; ckpt_restore = 1'b0; ckpt_restore_id = '0;
        @(posedge clk);
        #1;
        rst_n = 1'b1;
    endtask

    initial begin
        int m;
        int idx;
        int tg [2];
        rst_n = 1'b0;
        alloc_req = '0; ret_valid = '0; ret_tag = '0;
        ckpt_save = 1'b0; ckpt_save_id = '0; ckpt_restore = 1'b0; ckpt_restore_id = '0;
        do_reset();

        // First allocation after reset
        alloc2(); #1;
        chk("lit_first_ok", int'(alloc_ok), 1);
        chk("lit_first_tag0", int'(alloc_tag[5:0]), 32);
        chk("lit_first_tag1", int'(alloc_tag[11:6]), 33);
        idle(); #1;
        chk("lit_count_30", int'(free_count), 30);

        // Drain to empty, then a refused single request
        repeat (15) alloc2();
        idle(); #1;
        chk("lit_drained", int'(free_count), 0);
        chk("lit_empty", int'(empty), 1);
        drive(2'b01, 2'b00, 0, 0, 1'b0, 0, 1'b0, 0); #1;
        chk("lit_empty_refuse", int'(alloc_ok), 0);
        idle(); #1;
        chk("lit_head_held", int'(free_count), 0);

        // One free tag: 2-wide refused, single lane-1 request served
        drive(2'b00, 2'b01, 7, 0, 1'b0, 0, 1'b0, 0);
        alloc2(); #1;
        chk("lit_one_free", int'(free_count), 1);
        chk("lit_all_or_nothing", int'(alloc_ok), 0);
        drive(2'b10, 2'b00, 0, 0, 1'b0, 0, 1'b0, 0); #1;
        chk("lit_lane1_ok", int'(alloc_ok), 1);
        chk("lit_lane1_tag", int'(alloc_tag[11:6]), 7);
        idle(); #1;
        chk("lit_zero_again", int'(free_count), 0);

        // Checkpoint at head=4, allocate 36..41, restore with a same-cycle return
        do_reset();
        alloc2(); alloc2();
        drive(2'b00, 2'b00, 0, 0, 1'b1, 2, 1'b0, 0);
        for (int c = 0; c < 3; c++) begin
            alloc2(); #1;
            chk("lit_pre_tag0", int'(alloc_tag[5:0]), 36 + 2*c);
            chk("lit_pre_tag1", int'(alloc_tag[11:6]), 37 + 2*c);
        end
        drive(2'b11, 2'b01, 5, 0, 1'b0, 0, 1'b1, 2); #1;
        chk("lit_restore_blocks", int'(alloc_ok), 0);
        idle(); #1;
        chk("lit_restore_count", int'(free_count), 29);
        for (int c = 0; c < 3; c++) begin
            alloc2(); #1;
            chk("lit_reissue_tag0", int'(alloc_tag[5:0]), 36 + 2*c);
            chk("lit_reissue_tag1", int'(alloc_tag[11:6]), 37 + 2*c);
        end
        drive(2'b00, 2'b00, 0, 0, 1'b1, 1, 1'b1, 2);
        alloc2();
        drive(2'b00, 2'b00, 0, 0, 1'b0, 0, 1'b1, 1);
        idle(); #1;
        chk("lit_save_on_restore", int'(free_count), 29);

        // Fill to capacity; overflowing lanes are dropped and the error is sticky
        do_reset();
        for (int i = 0; i < 15; i++) drive(2'b00, 2'b11, 2*i, 2*i + 1, 1'b0, 0, 1'b0, 0);
        drive(2'b00, 2'b01, 30, 0, 1'b0, 0, 1'b0, 0);
        drive(2'b00, 2'b11, 31, 50, 1'b0, 0, 1'b0, 0);
        idle(); #1;
        chk("lit_full_count", int'(free_count), 64);
        chk("lit_full", int'(full), 1);
        chk("lit_partial_drop", int'(overflow_err), 1);
        drive(2'b00, 2'b11, 1, 2, 1'b0, 0, 1'b0, 0);
        idle(); #1;
        chk("lit_full_drop", int'(free_count), 64);
        repeat (3) idle();
        #1;
        chk("lit_ovf_sticky", int'(overflow_err), 1);
        do_reset();
        #1;
        chk("lit_ovf_cleared", int'(overflow_err), 0);

        // Random alloc/return traffic across pointer wrap with ownership tracking
        own_en = 1'b1;
        for (int cyc = 0; cyc < 200; cyc++) begin
            m = $urandom_range(0, 2);
            if (m > held.size()) m = held.size();
            tg[0] = 0;
            tg[1] = 0;
            for (int j = 0; j < m; j++) begin
                idx = $urandom_range(0, held.size() - 1);
                tg[j] = held[idx];
                held.delete(idx);
            end
            drive(2'($urandom_range(0, 3)), (m == 2) ? 2'b11 : (m == 1) ? 2'b01 : 2'b00,
                  tg[0], tg[1], 1'b0, 0, 1'b0, 0);
        end
        idle(); #1;
        chk("lit_no_tag_lost", int'(free_count), NPR - held.size());
        chk("lit_no_ovf_random", int'(overflow_err), 0);
        own_en = 1'b0;
        idle();

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
